seqmultiplier: RTL and testbench
================================

# seqmultiplier

Sequential shift-and-add unsigned multiplier datapath, directly downstream of the control unit that asserts `loaddata`. It captures two N-bit operands when `loaddata` is sampled high, runs N add/shift iterations, then presents a 2N-bit product with a `done` flag. It is the consumer of the control unit's load command and the block that performs the actual multiplication.

## Interface
Parameters:
- N, 8, operand width in bits (N ≥ 2)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset; one clock domain, no asynchronous reset path
- loaddata  input  1  load/start command from the control unit; sampled on rising edge
- dataA  input  N  multiplicand, unsigned; sampled only when a load is accepted
- dataB  input  N  multiplier, unsigned; sampled only when a load is accepted
- product  output  2N  result register, unsigned
- done  output  1  high while a valid result is held (state DONE)
- busy  output  1  high while iterating (state RUN)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `busy`=0, `done`=0.
  - `loaddata`=1 → accept load, go to RUN.
- Accepting a load (from IDLE or DONE):
  - `regA` ← zero-extended `dataA` (2N bits).
  - `regB` ← `dataB`.
  - `acc` ← 0.
  - `count` ← 0.
- RUN, each cycle:
  - If `regB[0]`=1: `acc` ← `acc` + `regA` (2N-bit add).
  - `regA` ← `regA` << 1.
  - `regB` ← `regB` >> 1.
  - `count` ← `count` + 1.
- RUN exit: on the edge where `count`=N−1, the iteration completes, `product` ← final sum (`acc` + conditional `regA` of that iteration), and the FSM goes to DONE.
- Iteration count: always exactly N. There is no early exit when `regB` becomes 0.
- DONE:
  - `done`=1; `product` held stable.
  - `loaddata`=1 → accept a new load, go to RUN. `done` falls on the same edge.
  - `loaddata`=0 → stay in DONE indefinitely.
- `loaddata` during RUN is ignored. Operands are not re-sampled and the computation continues undisturbed.
- `dataA`/`dataB` may change freely except on the load edge.
- Arithmetic:
  - Unsigned only.
  - `acc` is 2N bits; (2^N−1)^2 < 2^2N, so no overflow.
  - `count` is ⌈log2 N⌉ bits.
- `product` updates only on RUN→DONE. During RUN it keeps the previous result (0 after reset).
- `busy` and `done` are decoded from state (Moore outputs) and are never high together.

## Timing
- Reset values:
  - State IDLE.
  - `product`=0, `done`=0, `busy`=0.
  - `acc`, `regA`, `regB`, `count`=0.
- Reset has priority over `loaddata` on the same edge.
- Reset mid-RUN aborts the computation. No result is written, and `product` is cleared to 0.
- Load accepted on edge k:
  - `busy`=1 during cycles k..k+N−1.
  - Iterations occur on edges k+1..k+N.
  - `done`=1 and `product` valid from edge k+N onward.
  - Latency from load to result: N cycles.
- Back-to-back operation: `loaddata` held high continuously gives one result every N+1 cycles (load edge, N RUN edges, reload edge from DONE). `done` is high for exactly one cycle per result.
- IDLE→RUN and DONE→RUN behave identically.

## Structure
- Shared package `mult_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE}` for the state type.
  - Default width constant `MULT_N` = 8, referenced by the control unit and this block.
- Top `seqmultiplier` holds the FSM (sequential state register plus combinational next-state/output logic).
- One sub-module, `multdatapath`: `regA`/`regB`/`acc`/`count` registers, adder, shifters, and a `last` flag (`count`==N−1).
  - Controlled by `load` and `step` from the FSM.

## Test plan
- Basic, N=8: reset, then `dataA`=3, `dataB`=5, `loaddata` 1 for one cycle.
  - Required: `busy`=1 for 8 cycles, then `done`=1 and `product`=15 on the 8th edge after the load.
- Extremes, N=8:
  - 255×255 → `product`=65025.
  - 0×200 → 0.
  - 200×0 → 0.
  - 1×1 → 1.
  - Latency is 8 cycles in every case.
- Load ignored in RUN: start 12×10, pulse `loaddata` with `dataA`=7, `dataB`=7 at the 3rd RUN cycle.
  - Required: `product`=120, no restart, `done` on schedule.
- Reset mid-run: start 100×100, assert `reset` at the 4th RUN cycle.
  - Required: next cycle IDLE, `busy`=0, `done`=0, `product`=0.
  - No `done` appears afterwards.
- Reload from DONE: after the result 6×7=42, hold `done` for 3 cycles, then load 9×9.
  - Required: `product` stays 42 through RUN; `done` falls on the load edge.
  - 8 cycles later `product`=81 and `done`=1.
- Continuous `loaddata`=1 with 2×3: required `done` pulses exactly every 9 cycles, with `product`=6 each time.

Source files
------------

// File: rtl/seqmultiplier_pkg.sv
// Shared definitions for the sequential multiplier and its control unit.
package mult_pkg;

    localparam int unsigned MULT_N = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/seqmultiplier_datapath.sv
// Shift-and-add datapath: operand registers, accumulator and iteration counter.
module multdatapath
    import mult_pkg::*;
#(
    parameter int unsigned N = MULT_N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   data_a,
    input  logic [N-1:0]   data_b,
    output logic [2*N-1:0] sum,
    output logic           last
);

    localparam int unsigned CW = $clog2(N);

    logic [2*N-1:0] reg_a_q, reg_a_d;
    logic [N-1:0]   reg_b_q, reg_b_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  count_q, count_d;

    // sum is this iteration's accumulator result; the FSM captures it on the last step
    always_comb begin
        sum  = acc_q + (reg_b_q[0] ? reg_a_q : '0);
        last = (count_q == CW'(N - 1));

        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        acc_d   = acc_q;
        count_d = count_q;

        if (load) begin
            reg_a_d = {{N{1'b0}}, data_a};
            reg_b_d = data_b;
            acc_d   = '0;
            count_d = '0;
        end else if (step) begin
            acc_d   = sum;
            reg_a_d = reg_a_q << 1;
            reg_b_d = reg_b_q >> 1;
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_a_q <= '0;
            reg_b_q <= '0;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seqmultiplier.sv
// Sequential unsigned multiplier: FSM sequencing the shift-and-add datapath.
module seqmultiplier
    import mult_pkg::*;
#(
    parameter int unsigned N = MULT_N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           loaddata,
    input  logic [N-1:0]   dataA,
    input  logic [N-1:0]   dataB,
    output logic [2*N-1:0] product,
    output logic           done,
    output logic           busy
);

    state_t         state_q, state_d;
    logic [2*N-1:0] product_q, product_d;
    logic           load;
    logic           step;
    logic [2*N-1:0] sum;
    logic           last;

    multdatapath #(
        .N(N)
    ) u_datapath (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .data_a(dataA),
        .data_b(dataB),
        .sum   (sum),
        .last  (last)
    );

    always_comb begin
        state_d   = state_q;
        product_d = product_q;
        load      = 1'b0;
        step      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (loaddata) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    product_d = sum;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_seqmultiplier.sv
// Directed and randomized checks of seqmultiplier against arithmetic a*b and cycle schedule.
module tb_seqmultiplier;

    localparam int N = 8;

    logic           clk;
    logic           reset;
    logic           loaddata;
    logic [N-1:0]   dataA;
    logic [N-1:0]   dataB;
    logic [2*N-1:0] product;
    logic           done;
    logic           busy;

    int total;
    int bad;
    logic [2*N-1:0] exp_prod;

    seqmultiplier #(
        .N(N)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .loaddata(loaddata),
        .dataA   (dataA),
        .dataB   (dataB),
        .product (product),
        .done    (done),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One full operation: load on the next edge, N busy cycles, then result.
    // glitch_at >= 0 pulses loaddata with other operands during that RUN cycle;
    // rst_at >= 0 asserts reset during that RUN cycle and ends the task early.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input int glitch_at, input int rst_at);
        logic [2*N-1:0] prev;
        prev = exp_prod;
        @(negedge clk);
        loaddata = 1'b1;
        dataA    = a;
        dataB    = b;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            loaddata = 1'b0;
            dataA    = N'($urandom);
            dataB    = N'($urandom);
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'd0);
            chk("run_hold", 32'(product), 32'(prev));
            if (i == glitch_at) begin
                loaddata = 1'b1;
                dataA    = 7;
                dataB    = 7;
            end
            if (i == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                exp_prod = '0;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_prod", 32'(product), 32'd0);
                for (int j = 0; j < 2 * N; j++) begin
                    @(negedge clk);
                    chk("rst_nodone", 32'(done), 32'd0);
                end
                return;
            end
        end
        @(negedge clk);
        loaddata = 1'b0;
        exp_prod = (2*N)'(32'(a) * 32'(b));
        chk("res_done", 32'(done), 32'd1);
        chk("res_busy", 32'(busy), 32'd0);
        chk("res_prod", 32'(product), 32'(exp_prod));
    endtask

    initial begin
        int last_done;
        int pulses;
        logic [N-1:0] ra, rb;

        total    = 0;
        bad      = 0;
        exp_prod = '0;
        reset    = 1'b1;
        loaddata = 1'b0;
        dataA    = '0;
        dataB    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_prod", 32'(product), 32'd0);

        // reset wins over a simultaneous load
        loaddata = 1'b1;
        dataA    = 9;
        dataB    = 9;
        @(negedge clk);
        chk("rst_prio_busy", 32'(busy), 32'd0);
        reset    = 1'b0;
        loaddata = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        run_op(3, 5, -1, -1);
        run_op(255, 255, -1, -1);
        run_op(0, 200, -1, -1);
        run_op(200, 0, -1, -1);
        run_op(1, 1, -1, -1);
        run_op(12, 10, 2, -1);
        run_op(100, 100, -1, 3);

        run_op(6, 7, -1, -1);
        repeat (2) begin
            @(negedge clk);
            chk("hold_done", 32'(done), 32'd1);
            chk("hold_prod", 32'(product), 32'd42);
        end
        run_op(9, 9, -1, -1);

        for (int t = 0; t < 8; t++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            run_op(ra, rb, -1, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // continuous loaddata: one result every N+1 cycles
        @(negedge clk);
        loaddata  = 1'b1;
        dataA     = 2;
        dataB     = 3;
        last_done = -1;
        pulses    = 0;
        for (int c = 1; c <= 5 * (N + 1); c++) begin
            @(negedge clk);
            if (done) begin
                chk("cont_prod", 32'(product), 32'd6);
                if (last_done >= 0) chk("cont_period", 32'(c - last_done), 32'(N + 1));
                else chk("cont_first", 32'(c), 32'(N + 1));
                last_done = c;
                pulses++;
            end
        end
        loaddata = 1'b0;
        chk("cont_pulses", 32'(pulses), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
